// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: FSM states, 2-bit counter encodings and the saturating-counter helper
package branch_resolve_unit_pkg;
    typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} brs_state_t;
    localparam logic [1:0] CB_SNT = 2'b00;
    localparam logic [1:0] CB_WNT = 2'b01;
    localparam logic [1:0] CB_WT = 2'b10;
    localparam logic [1:0] CB_ST = 2'b11;
    localparam logic [1:0] ALLOC_CB_DEFAULT = CB_WT;
    function automatic logic [1:0] sat_next(input logic [1:0] cb, input logic up);
        return up ? ((cb == CB_ST) ? CB_ST : cb + 2'd1) : ((cb == CB_SNT) ? CB_SNT : cb - 2'd1);
    endfunction
endpackage

// File: rtl/branch_resolve_unit_sat_counter2.sv
// sat_counter2: next value of a 2-bit up/down saturating predictor counter
module sat_counter2
    import branch_resolve_unit_pkg::*;
(
    input  logic [1:0] i_cb,
    input  logic       i_up,
    output logic [1:0] o_cb
);
    assign o_cb = sat_next(i_cb, i_up);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches, drives PC redirect/flush and predict-cache updates
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] ALLOC_CB = ALLOC_CB_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EX_Valid,
    input  logic              EX_Stall,
    input  logic              IsJump,
    input  logic              CondTaken,
    input  logic [ADDR_W-1:0] TargetAddr,
    input  logic [ADDR_W-1:0] BrInstrAddr,
    input  logic [ADDR_W-1:0] SeqPC,
    input  logic              PredHit,
    input  logic              PCSource,
    input  logic [ADDR_W-1:0] Predict,
    input  logic [1:0]        CB,
    output logic [ADDR_W-1:0] JmpAddr,
    output logic [ADDR_W-1:0] JmpInstrAddr,
    output logic              WriteEnable,
    output logic [1:0]        CB_o,
    output logic              FlushPipeandPC,
    output logic              BruBusy,
    output logic [CNT_W-1:0]  BranchCount,
    output logic [CNT_W-1:0]  MispredictCount
);
    brs_state_t        r_state;
    logic [ADDR_W-1:0] r_jmp_addr, r_jmp_instr_addr, r_pend_data;
    logic [1:0]        r_cb;
    logic              r_we, r_flush, r_busy;
    logic [CNT_W-1:0]  r_br_cnt, r_mis_cnt;
    logic              w_accept, w_taken, w_mispredict, w_write, w_split;
    logic [ADDR_W-1:0] w_actual, w_wdata;
    logic [1:0]        w_cb_upd, w_cb_new;

    sat_counter2 u_sat (.i_cb(CB), .i_up(w_taken), .o_cb(w_cb_upd));

    assign w_accept     = EX_Valid & ~EX_Stall & (r_state == IDLE);
    assign w_taken      = IsJump | CondTaken;
    assign w_actual     = w_taken ? TargetAddr : SeqPC;
    assign w_mispredict = (PCSource != w_taken) | (PCSource & w_taken & (Predict != TargetAddr));
    assign w_write      = PredHit | w_taken;
    assign w_wdata      = w_taken ? TargetAddr : Predict;
    assign w_cb_new     = PredHit ? w_cb_upd : ALLOC_CB;
    // Only a not-taken mispredict on a hit needs SeqPC and Predict on JmpAddr at once.
    assign w_split      = w_mispredict & w_write & (w_wdata != w_actual);

    // In the split case JmpInstrAddr and CB_o already hold the write index/value for UPDATE.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state          <= IDLE;
            r_jmp_addr       <= '0;
            r_jmp_instr_addr <= '0;
            r_pend_data      <= '0;
            r_cb             <= '0;
            r_we             <= 1'b0;
            r_flush          <= 1'b0;
            r_busy           <= 1'b0;
            r_br_cnt         <= '0;
            r_mis_cnt        <= '0;
        end else begin
            r_we    <= 1'b0;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
            if (r_state == UPDATE) begin
                r_state    <= IDLE;
                r_we       <= 1'b1;
                r_busy     <= 1'b1;
                r_jmp_addr <= r_pend_data;
            end else if (w_accept) begin
                r_br_cnt         <= r_br_cnt + CNT_W'(1);
                r_mis_cnt        <= r_mis_cnt + CNT_W'(w_mispredict);
                r_flush          <= w_mispredict;
                r_we             <= w_write & ~w_split;
                r_jmp_addr       <= (w_write & ~w_split) ? w_wdata : w_actual;
                r_jmp_instr_addr <= BrInstrAddr;
                r_cb             <= w_cb_new;
                r_pend_data      <= Predict;
                r_state          <= w_split ? UPDATE : IDLE;
            end
        end
    end

    assign JmpAddr         = r_jmp_addr;
    assign JmpInstrAddr    = r_jmp_instr_addr;
    assign WriteEnable     = r_we;
    assign CB_o            = r_cb;
    assign FlushPipeandPC  = r_flush;
    assign BruBusy         = r_busy;
    assign BranchCount     = r_br_cnt;
    assign MispredictCount = r_mis_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus randomized branches against a rule-level model
module tb_branch_resolve_unit;
    logic        Clk = 1'b0, Rst = 1'b1;
    logic        EX_Valid = 1'b0, EX_Stall = 1'b0, IsJump = 1'b0, CondTaken = 1'b0;
    logic        PredHit = 1'b0, PCSource = 1'b0;
    logic [31:0] TargetAddr = '0, BrInstrAddr = '0, SeqPC = '0, Predict = '0;
    logic [1:0]  CB = '0;
    logic [31:0] JmpAddr, JmpInstrAddr;
    logic        WriteEnable, FlushPipeandPC, BruBusy;
    logic [1:0]  CB_o;
    logic [15:0] BranchCount, MispredictCount;
    int          checks = 0, errors = 0;
    logic [15:0] exp_bc = '0, exp_mc = '0;

    typedef struct packed {
        logic        mis;
        logic        split;
        logic        flush1;
        logic        we1;
        logic [31:0] jmp1;
        logic [1:0]  cb;
    } exp_t;

    branch_resolve_unit dut (
        .Clk(Clk), .Rst(Rst), .EX_Valid(EX_Valid), .EX_Stall(EX_Stall), .IsJump(IsJump),
        .CondTaken(CondTaken), .TargetAddr(TargetAddr), .BrInstrAddr(BrInstrAddr), .SeqPC(SeqPC),
        .PredHit(PredHit), .PCSource(PCSource), .Predict(Predict), .CB(CB), .JmpAddr(JmpAddr),
        .JmpInstrAddr(JmpInstrAddr), .WriteEnable(WriteEnable), .CB_o(CB_o),
        .FlushPipeandPC(FlushPipeandPC), .BruBusy(BruBusy), .BranchCount(BranchCount),
        .MispredictCount(MispredictCount)
    );

    always #5 Clk = ~Clk;

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_br(input logic ij, ct, ph, pcs, input logic [31:0] tgt, bia, seq, pred, input logic [1:0] cb);
        IsJump = ij; CondTaken = ct; PredHit = ph; PCSource = pcs;
        TargetAddr = tgt; BrInstrAddr = bia; SeqPC = seq; Predict = pred; CB = cb;
    endtask

    task automatic accept;
        EX_Valid = 1'b1;
        step;
        EX_Valid = 1'b0;
    endtask

    function automatic exp_t model(input logic ij, ct, ph, pcs, input logic [31:0] tgt, seq, pred, input logic [1:0] cb);
        exp_t e;
        bit taken, wr;
        int c;
        logic [31:0] act, wd;
        taken = ij || ct;
        act = taken ? tgt : seq;
        wd = taken ? tgt : pred;
        wr = ph || taken;
        c = int'(cb);
        c = taken ? ((c >= 3) ? 3 : c + 1) : ((c <= 0) ? 0 : c - 1);
        e.mis = (pcs != taken) || (pcs && taken && pred != tgt);
        e.cb = ph ? 2'(c) : 2'b10;
        e.split = e.mis && wr && wd != act;
        e.flush1 = e.mis;
        e.we1 = wr && !e.split;
        e.jmp1 = e.we1 ? wd : act;
        return e;
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if ({JmpAddr, JmpInstrAddr, WriteEnable, CB_o, FlushPipeandPC, BruBusy, BranchCount, MispredictCount} !== '0) begin
            errors++;
            $display("FAIL reset: got jmp=%h jia=%h we=%b cb=%b flush=%b busy=%b bc=%0d mc=%0d, expected all 0",
                     JmpAddr, JmpInstrAddr, WriteEnable, CB_o, FlushPipeandPC, BruBusy, BranchCount, MispredictCount);
        end
        step;
        step;
        Rst = 1'b0;
        step;
    endtask

    task automatic test_hit_taken;
        set_br(0, 1, 1, 1, 32'h100, 32'h10, 32'h14, 32'h100, 2'b10);
        accept;
        exp_bc++;
        checks++;
        if (WriteEnable !== 1'b1 || CB_o !== 2'b11 || FlushPipeandPC !== 1'b0 || JmpAddr !== 32'h100 ||
            JmpInstrAddr !== 32'h10 || BruBusy !== 1'b0 || BranchCount !== exp_bc || MispredictCount !== exp_mc) begin
            errors++;
            $display("FAIL hit_taken: got we=%b cb=%b flush=%b jmp=%h jia=%h busy=%b bc=%0d mc=%0d, expected we=1 cb=11 flush=0 jmp=100 jia=10 busy=0 bc=%0d mc=%0d",
                     WriteEnable, CB_o, FlushPipeandPC, JmpAddr, JmpInstrAddr, BruBusy, BranchCount, MispredictCount, exp_bc, exp_mc);
        end
        step;
        checks++;
        if (WriteEnable !== 1'b0 || FlushPipeandPC !== 1'b0) begin
            errors++;
            $display("FAIL hit_taken_strobe: got we=%b flush=%b, expected we=0 flush=0", WriteEnable, FlushPipeandPC);
        end
    endtask

    task automatic test_miss_jump;
        set_br(1, 0, 0, 0, 32'h200, 32'h40, 32'h44, 32'h0, 2'b00);
        accept;
        exp_bc++;
        exp_mc++;
        checks++;
        if (FlushPipeandPC !== 1'b1 || WriteEnable !== 1'b1 || JmpAddr !== 32'h200 || JmpInstrAddr !== 32'h40 ||
            CB_o !== 2'b10 || MispredictCount !== exp_mc) begin
            errors++;
            $display("FAIL miss_jump: got flush=%b we=%b jmp=%h jia=%h cb=%b mc=%0d, expected flush=1 we=1 jmp=200 jia=40 cb=10 mc=%0d",
                     FlushPipeandPC, WriteEnable, JmpAddr, JmpInstrAddr, CB_o, MispredictCount, exp_mc);
        end
        step;
        checks++;
        if (WriteEnable !== 1'b0 || FlushPipeandPC !== 1'b0 || BruBusy !== 1'b0) begin
            errors++;
            $display("FAIL miss_jump_strobe: got we=%b flush=%b busy=%b, expected 0 0 0", WriteEnable, FlushPipeandPC, BruBusy);
        end
    endtask

    task automatic test_nt_mispredict;
        set_br(0, 0, 1, 1, 32'h300, 32'h40, 32'h44, 32'h300, 2'b11);
        accept;
        exp_bc++;
        exp_mc++;
        set_br(0, 0, 0, 0, 32'hdead, 32'hbeef, 32'h0, 32'hdead, 2'b00);
        checks++;
        if (FlushPipeandPC !== 1'b1 || JmpAddr !== 32'h44 || WriteEnable !== 1'b0 || BruBusy !== 1'b0 || MispredictCount !== exp_mc) begin
            errors++;
            $display("FAIL nt_mis_c1: got flush=%b jmp=%h we=%b busy=%b mc=%0d, expected flush=1 jmp=44 we=0 busy=0 mc=%0d",
                     FlushPipeandPC, JmpAddr, WriteEnable, BruBusy, MispredictCount, exp_mc);
        end
        step;
        checks++;
        if (WriteEnable !== 1'b1 || JmpAddr !== 32'h300 || JmpInstrAddr !== 32'h40 || CB_o !== 2'b10 ||
            BruBusy !== 1'b1 || FlushPipeandPC !== 1'b0) begin
            errors++;
            $display("FAIL nt_mis_c2: got we=%b jmp=%h jia=%h cb=%b busy=%b flush=%b, expected we=1 jmp=300 jia=40 cb=10 busy=1 flush=0",
                     WriteEnable, JmpAddr, JmpInstrAddr, CB_o, BruBusy, FlushPipeandPC);
        end
        step;
        checks++;
        if (WriteEnable !== 1'b0 || BruBusy !== 1'b0 || BranchCount !== exp_bc) begin
            errors++;
            $display("FAIL nt_mis_c3: got we=%b busy=%b bc=%0d, expected we=0 busy=0 bc=%0d", WriteEnable, BruBusy, BranchCount, exp_bc);
        end
    endtask

    task automatic test_wrong_target;
        set_br(0, 1, 1, 1, 32'h600, 32'h80, 32'h84, 32'h500, 2'b10);
        accept;
        exp_bc++;
        exp_mc++;
        checks++;
        if (FlushPipeandPC !== 1'b1 || WriteEnable !== 1'b1 || JmpAddr !== 32'h600 || CB_o !== 2'b11 ||
            JmpInstrAddr !== 32'h80 || MispredictCount !== exp_mc) begin
            errors++;
            $display("FAIL wrong_target: got flush=%b we=%b jmp=%h cb=%b jia=%h mc=%0d, expected flush=1 we=1 jmp=600 cb=11 jia=80 mc=%0d",
                     FlushPipeandPC, WriteEnable, JmpAddr, CB_o, JmpInstrAddr, MispredictCount, exp_mc);
        end
        step;
    endtask

    task automatic test_stall;
        set_br(0, 1, 1, 1, 32'h900, 32'h90, 32'h94, 32'h900, 2'b01);
        EX_Valid = 1'b1;
        EX_Stall = 1'b1;
        repeat (3) begin
            step;
            checks++;
            if (WriteEnable !== 1'b0 || FlushPipeandPC !== 1'b0 || BranchCount !== exp_bc) begin
                errors++;
                $display("FAIL stall_hold: got we=%b flush=%b bc=%0d, expected we=0 flush=0 bc=%0d", WriteEnable, FlushPipeandPC, BranchCount, exp_bc);
            end
        end
        EX_Stall = 1'b0;
        step;
        EX_Valid = 1'b0;
        exp_bc++;
        checks++;
        if (WriteEnable !== 1'b1 || JmpAddr !== 32'h900 || CB_o !== 2'b10 || BranchCount !== exp_bc) begin
            errors++;
            $display("FAIL stall_release: got we=%b jmp=%h cb=%b bc=%0d, expected we=1 jmp=900 cb=10 bc=%0d", WriteEnable, JmpAddr, CB_o, BranchCount, exp_bc);
        end
        step;
        step;
        checks++;
        if (WriteEnable !== 1'b0 || BranchCount !== exp_bc) begin
            errors++;
            $display("FAIL stall_once: got we=%b bc=%0d, expected we=0 bc=%0d", WriteEnable, BranchCount, exp_bc);
        end
    endtask

    task automatic test_back_to_back;
        set_br(0, 0, 1, 1, 32'h0, 32'h20, 32'h24, 32'h350, 2'b10);
        EX_Valid = 1'b1;
        step;
        exp_bc++;
        exp_mc++;
        set_br(0, 1, 1, 1, 32'h700, 32'h70, 32'h74, 32'h700, 2'b01);
        checks++;
        if (FlushPipeandPC !== 1'b1 || JmpAddr !== 32'h24 || WriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL b2b_c1: got flush=%b jmp=%h we=%b, expected flush=1 jmp=24 we=0", FlushPipeandPC, JmpAddr, WriteEnable);
        end
        step;
        checks++;
        if (WriteEnable !== 1'b1 || JmpAddr !== 32'h350 || JmpInstrAddr !== 32'h20 || CB_o !== 2'b01 ||
            BruBusy !== 1'b1 || BranchCount !== exp_bc) begin
            errors++;
            $display("FAIL b2b_update: got we=%b jmp=%h jia=%h cb=%b busy=%b bc=%0d, expected we=1 jmp=350 jia=20 cb=01 busy=1 bc=%0d",
                     WriteEnable, JmpAddr, JmpInstrAddr, CB_o, BruBusy, BranchCount, exp_bc);
        end
        step;
        EX_Valid = 1'b0;
        exp_bc++;
        checks++;
        if (WriteEnable !== 1'b1 || JmpAddr !== 32'h700 || JmpInstrAddr !== 32'h70 || CB_o !== 2'b10 ||
            BruBusy !== 1'b0 || FlushPipeandPC !== 1'b0 || BranchCount !== exp_bc || MispredictCount !== exp_mc) begin
            errors++;
            $display("FAIL b2b_second: got we=%b jmp=%h jia=%h cb=%b busy=%b flush=%b bc=%0d mc=%0d, expected we=1 jmp=700 jia=70 cb=10 busy=0 flush=0 bc=%0d mc=%0d",
                     WriteEnable, JmpAddr, JmpInstrAddr, CB_o, BruBusy, FlushPipeandPC, BranchCount, MispredictCount, exp_bc, exp_mc);
        end
        step;
    endtask

    task automatic test_reset_mid_update;
        set_br(0, 0, 1, 1, 32'h0, 32'h60, 32'h64, 32'h360, 2'b11);
        accept;
        checks++;
        if (FlushPipeandPC !== 1'b1 || WriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: got flush=%b we=%b, expected flush=1 we=0", FlushPipeandPC, WriteEnable);
        end
        #2;
        Rst = 1'b1;
        #1;
        exp_bc = '0;
        exp_mc = '0;
        checks++;
        if ({JmpAddr, JmpInstrAddr, WriteEnable, CB_o, FlushPipeandPC, BruBusy, BranchCount, MispredictCount} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got jmp=%h jia=%h we=%b cb=%b flush=%b busy=%b bc=%0d mc=%0d, expected all 0",
                     JmpAddr, JmpInstrAddr, WriteEnable, CB_o, FlushPipeandPC, BruBusy, BranchCount, MispredictCount);
        end
        step;
        Rst = 1'b0;
        repeat (2) begin
            step;
            checks++;
            if (WriteEnable !== 1'b0 || BruBusy !== 1'b0 || FlushPipeandPC !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_nowrite: got we=%b busy=%b flush=%b, expected 0 0 0", WriteEnable, BruBusy, FlushPipeandPC);
            end
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic ij, ct, ph, pcs;
        logic [31:0] tgt, bia, pred;
        logic [1:0] cb;
        for (int n = 0; n < 300; n++) begin
            ij = 1'($urandom_range(0, 3) == 0);
            ct = 1'($urandom_range(0, 1));
            ph = 1'($urandom_range(0, 1));
            pcs = ph & 1'($urandom_range(0, 1));
            tgt = 32'($urandom_range(0, 63)) << 2;
            bia = 32'($urandom_range(64, 1023)) << 2;
            pred = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 63)) << 2 : tgt;
            cb = 2'($urandom_range(0, 3));
            e = model(ij, ct, ph, pcs, tgt, bia + 32'd4, pred, cb);
            set_br(ij, ct, ph, pcs, tgt, bia, bia + 32'd4, pred, cb);
            accept;
            exp_bc++;
            exp_mc += 16'(e.mis);
            set_br(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
            checks++;
            if (FlushPipeandPC !== e.flush1 || WriteEnable !== e.we1 || BruBusy !== 1'b0 ||
                ((e.flush1 || e.we1) && JmpAddr !== e.jmp1) || (e.we1 && (JmpInstrAddr !== bia || CB_o !== e.cb))) begin
                errors++;
                $display("FAIL rand_beat1[%0d]: got flush=%b we=%b busy=%b jmp=%h jia=%h cb=%b, expected flush=%b we=%b busy=0 jmp=%h jia=%h cb=%b",
                         n, FlushPipeandPC, WriteEnable, BruBusy, JmpAddr, JmpInstrAddr, CB_o, e.flush1, e.we1, e.jmp1, bia, e.cb);
            end
            if (e.split) begin
                step;
                checks++;
                if (FlushPipeandPC !== 1'b0 || WriteEnable !== 1'b1 || BruBusy !== 1'b1 || JmpAddr !== pred ||
                    JmpInstrAddr !== bia || CB_o !== e.cb) begin
                    errors++;
                    $display("FAIL rand_beat2[%0d]: got flush=%b we=%b busy=%b jmp=%h jia=%h cb=%b, expected flush=0 we=1 busy=1 jmp=%h jia=%h cb=%b",
                             n, FlushPipeandPC, WriteEnable, BruBusy, JmpAddr, JmpInstrAddr, CB_o, pred, bia, e.cb);
                end
            end
            checks++;
            if (BranchCount !== exp_bc || MispredictCount !== exp_mc) begin
                errors++;
                $display("FAIL rand_counts[%0d]: got bc=%0d mc=%0d, expected bc=%0d mc=%0d", n, BranchCount, MispredictCount, exp_bc, exp_mc);
            end
            if ($urandom_range(0, 1) == 1) begin
                step;
                checks++;
                if (WriteEnable !== 1'b0 || FlushPipeandPC !== 1'b0 || BruBusy !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle[%0d]: got we=%b flush=%b busy=%b, expected 0 0 0", n, WriteEnable, FlushPipeandPC, BruBusy);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_hit_taken;
        test_miss_jump;
        test_nt_mispredict;
        test_wrong_target;
        test_stall;
        test_back_to_back;
        test_reset_mid_update;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage partner of the fetch/predict-cache front end.
- Resolves each conditional branch or jump that leaves EX and compares the outcome with the prediction carried down the pipeline (PCSource, Predict, CB).
- Drives the PC redirect and flush (FlushPipeandPC, JmpAddr) and the predict-cache update (WriteEnable, JmpInstrAddr, JmpAddr as write data, CB_o).
- A small FSM splits redirect and cache update when they need different values on the shared JmpAddr bus.

Parameters:
- ADDR_W, 32, width of instruction addresses.
- CNT_W, 16, width of the branch and mispredict statistics counters.
- ALLOC_CB, 2'b10, counter value written when a new entry is allocated (weakly taken).

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-high reset.
- EX_Valid  in  1  EX holds a valid branch or jump.
- EX_Stall  in  1  EX held by the hazard unit.
- IsJump  in  1  1 = unconditional; 0 = conditional.
- CondTaken  in  1  branch condition from the ALU.
- TargetAddr  in  ADDR_W  computed target.
- BrInstrAddr  in  ADDR_W  address of the branch.
- SeqPC  in  ADDR_W  fall-through address.
- PredHit  in  1  predict cache hit at fetch.
- PCSource  in  1  fetch used the predicted target.
- Predict  in  ADDR_W  predicted target.
- CB  in  2  counter read at fetch.
- JmpAddr  out  ADDR_W  redirect address, or cache write data when WriteEnable=1.
- JmpInstrAddr  out  ADDR_W  cache write index.
- WriteEnable  out  1  predict cache write strobe.
- CB_o  out  2  counter value to write.
- FlushPipeandPC  out  1  redirect PC and flush IF/ID and ID/EX.
- BruBusy  out  1  stall request to the hazard unit.
- BranchCount  out  CNT_W  statistics.
- MispredictCount  out  CNT_W  statistics.

Behaviour:
Reset
- State IDLE; every output is 0.

Acceptance
- A branch is resolved once, at the rising edge where EX_Valid=1, EX_Stall=0 and state=IDLE.
- All outputs are registered: they appear in the cycle after acceptance and each strobe lasts exactly 1 cycle.

Outcome
- taken = IsJump | CondTaken.
- actual = taken ? TargetAddr : SeqPC.
- mispredict = (PCSource != taken) | (PCSource & taken & (Predict != TargetAddr)).

Counter update (2-bit saturating)
- Increment if taken, decrement if not; 11 and 00 saturate.
- On a hit, CB_o = updated CB.
- On a miss (PredHit=0), CB is ignored:
  - taken: allocate with CB_o = ALLOC_CB.
  - not taken: no write.

Write data
- Taken: TargetAddr.
- Not-taken hit: Predict (the stored target is kept).

Bus merge rule
- The redirect and the write share one cycle when no flush is needed, or when flush is needed and the write data equals actual.
- They split when flush is needed, a write is needed, and the write data differs from actual (the not-taken-mispredict-on-hit case).

FSM
- IDLE:
  - On accept with split: FlushPipeandPC=1, JmpAddr=SeqPC, WriteEnable=0; go to UPDATE.
  - Otherwise a single cycle of flush and/or write, then stay in IDLE.
- UPDATE (1 cycle): WriteEnable=1, JmpAddr=Predict (latched), JmpInstrAddr=BrInstrAddr (latched), BruBusy=1, FlushPipeandPC=0; return to IDLE.
- A valid branch presented during UPDATE is not accepted; it is accepted in the following IDLE cycle.

Other rules
- JmpInstrAddr = BrInstrAddr whenever WriteEnable=1.
- Outputs are don't-care when their strobe is 0 but must be held stable (no X).

Counters
- BranchCount increments on each accept; MispredictCount increments on each accept with mispredict=1.
- Both wrap modulo 2^CNT_W.

Reset mid-operation
- Rst asserted in UPDATE aborts the pending write.
- All outputs clear immediately (asynchronous).

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, UPDATE).
  - CB constants (SNT=00, WNT=01, WT=10, ST=11).
  - ALLOC_CB default.
  - A saturating-counter function.
- One natural sub-module: sat_counter2 (combinational next-value of the 2-bit counter, up/down with saturation). Everything else stays in branch_resolve_unit.

Test Plan:
1. Correct taken prediction, hit: PCSource=1, Predict=TargetAddr=0x100, CB=10, CondTaken=1 -> next cycle WriteEnable=1, CB_o=11, FlushPipeandPC=0, JmpAddr=0x100.
2. Miss with jump: PredHit=0, PCSource=0, IsJump=1, TargetAddr=0x200, BrInstrAddr=0x40 -> one cycle with FlushPipeandPC=1, WriteEnable=1, JmpAddr=0x200, JmpInstrAddr=0x40, CB_o=10; MispredictCount +1.
3. Predicted taken but not taken, hit, CB=11, Predict=0x300, SeqPC=0x44 -> cycle 1: Flush=1, JmpAddr=0x44, WE=0; cycle 2: WE=1, JmpAddr=0x300, CB_o=10, BruBusy=1.
4. Wrong target: PCSource=1, Predict=0x500, TargetAddr=0x600, CB=10 -> single cycle Flush=1, WE=1, JmpAddr=0x600, CB_o=11.
5. Stall handling: same branch held 3 cycles with EX_Stall=1, then released -> exactly one resolution; BranchCount +1.
6. Back-to-back and reset:
   - A valid branch presented during UPDATE is accepted one cycle later.
   - Rst asserted in UPDATE -> WriteEnable and all outputs 0 immediately; no write after reset release.
